// File: rtl/ts_rcv_pkg.sv
// Shared symbol codes, TS type encoding and the identity-key record used by
// the training-sequence receiver.
package ts_rcv_pkg;

  localparam logic [7:0] COM    = 8'hBC;  // K28.5, start of ordered set
  localparam logic [7:0] PADG12 = 8'hF7;  // K23.7, PAD link/lane number
  localparam logic [7:0] D10_2  = 8'h4A;  // TS1 identifier symbol
  localparam logic [7:0] D5_2   = 8'h45;  // TS2 identifier symbol

  typedef enum logic [1:0] {
    TS_NONE = 2'b00,
    TS_TS1  = 2'b01,
    TS_TS2  = 2'b10
  } ts_type_e;

  // Everything that must match for two TSs to count as identical.
  typedef struct packed {
    ts_type_e   typ;
    logic [7:0] link;
    logic [7:0] lane;
    logic [7:0] nfts;
    logic [7:0] rate;
    logic [7:0] ctrl;
  } ts_key_t;

endpackage

// File: rtl/ts_rcv_decode.sv
// Combinational classifier: one 16-symbol ordered set in, valid flag and
// identity key out. Symbol 0 sits in the top byte.
module ts_rcv_decode
  import ts_rcv_pkg::*;
(
  input  logic [127:0] ts,
  output logic         ok,
  output ts_key_t      key
);

  logic [15:0][7:0] sym;
  logic             same;

  // symbol i lives at sym[15-i]
  assign sym = ts;

  // Symbols 6..15 must all repeat symbol 6; symbol 6 then picks TS1/TS2.
  always_comb begin
    same = 1'b1;
    for (int i = 7; i < 16; i++)
      if (sym[15-i] != sym[9]) same = 1'b0;

    ok       = 1'b0;
    key      = '0;
    key.typ  = TS_NONE;
    if (sym[15] == COM && same && (sym[9] == D10_2 || sym[9] == D5_2)) begin
      ok      = 1'b1;
      key.typ = (sym[9] == D10_2) ? TS_TS1 : TS_TS2;
    end
    key.link = sym[14];
    key.lane = sym[13];
    key.nfts = sym[12];
    key.rate = sym[11];
    key.ctrl = sym[10];
  end

endmodule

// File: rtl/ts_rcv.sv
// Receive-side TS1/TS2 checker. Stage 1 holds the decoded ordered set,
// stage 2 tracks the run of identical TSs and reports to the LTSSM.
module ts_rcv
  import ts_rcv_pkg::*;
#(
  parameter int CONSEC_TARGET = 8,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_ts_valid,
  input  logic [127:0]     rx_ts,
  input  logic             ts_rcv_clr,
  output logic             to_tsa_ts1_rcvd_enough,
  output logic             to_tsa_ts2_rcvd_enough,
  output logic [1:0]       rx_ts_type,
  output logic [7:0]       rx_link_num,
  output logic [7:0]       rx_lane_num,
  output logic [5:0]       rx_rate,
  output logic [CNT_W-1:0] rx_consec_cnt,
  output logic             rx_ts_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TARGET  = CNT_W'(CONSEC_TARGET);

  typedef enum logic {S_IDLE, S_TRACK} state_e;

  logic    dec_ok;
  ts_key_t dec_key;

  logic    s1_vld;
  logic    s1_ok;
  ts_key_t s1_key;

  state_e           state;
  ts_key_t          ref_key;
  logic [CNT_W-1:0] cnt;
  logic             err;

  ts_rcv_decode u_dec (
    .ts  (rx_ts),
    .ok  (dec_ok),
    .key (dec_key)
  );

  // Stage 1: capture the decoded set; a clear discards the incoming one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_ok  <= 1'b0;
      s1_key <= '0;
    end else begin
      s1_vld <= rx_ts_valid & ~ts_rcv_clr;
      s1_ok  <= dec_ok;
      s1_key <= dec_key;
    end
  end

  // Stage 2: run tracker. Clear also drops whatever sits in stage 1.
  always_ff @(posedge clk) begin
    if (rst || ts_rcv_clr) begin
      state   <= S_IDLE;
      ref_key <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (s1_vld) begin
        if (!s1_ok) begin
          state   <= S_IDLE;
          ref_key <= '0;
          cnt     <= '0;
          err     <= 1'b1;
        end else if (state == S_TRACK && s1_key == ref_key) begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end else begin
          state   <= S_TRACK;
          ref_key <= s1_key;
          cnt     <= CNT_W'(1);
        end
      end
    end
  end

  assign rx_ts_type    = ref_key.typ;
  assign rx_link_num   = ref_key.link;
  assign rx_lane_num   = ref_key.lane;
  assign rx_rate       = ref_key.rate[5:0];
  assign rx_consec_cnt = cnt;
  assign rx_ts_err     = err;

  // Level flags straight off the registered run state; never sticky.
  assign to_tsa_ts1_rcvd_enough = (ref_key.typ == TS_TS1) && (cnt >= TARGET);
  assign to_tsa_ts2_rcvd_enough = (ref_key.typ == TS_TS2) && (cnt >= TARGET);

endmodule

// File: tb/tb_ts_rcv.sv
// Bench for ts_rcv: a transaction-level model of the run rules, checked
// against the DUT every cycle, plus literal spot checks on key scenarios.
module tb_ts_rcv;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_ts_valid;
  logic [127:0] rx_ts;
  logic         ts_rcv_clr;
  logic         ts1_en, ts2_en, err;
  logic [1:0]   typ;
  logic [7:0]   link, lane;
  logic [5:0]   rate;
  logic [3:0]   cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ts_rcv #(.CONSEC_TARGET(8), .CNT_W(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .rx_ts_valid            (rx_ts_valid),
    .rx_ts                  (rx_ts),
    .ts_rcv_clr             (ts_rcv_clr),
    .to_tsa_ts1_rcvd_enough (ts1_en),
    .to_tsa_ts2_rcvd_enough (ts2_en),
    .rx_ts_type             (typ),
    .rx_link_num            (link),
    .rx_lane_num            (lane),
    .rx_rate                (rate),
    .rx_consec_cnt          (cnt),
    .rx_ts_err              (err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [7:0] s0, input logic [7:0] rt,
                                      input logic [7:0] fill);
    return {s0, 8'hF7, 8'hF7, 8'hFF, rt, 8'h00, {10{fill}}};
  endfunction

  // 0 invalid, 1 TS1, 2 TS2
  function automatic int classify(input logic [127:0] t);
    logic [7:0] b[16];
    for (int i = 0; i < 16; i++) b[i] = t[127-8*i -: 8];
    if (b[0] != 8'hBC) return 0;
    for (int i = 7; i < 16; i++) if (b[i] != b[6]) return 0;
    if (b[6] == 8'h4A) return 1;
    if (b[6] == 8'h45) return 2;
    return 0;
  endfunction

  // ---------------- model ----------------
  int          m_type = 0;
  logic [39:0] m_syms = '0;
  int          m_cnt  = 0;
  bit          m_err  = 0;
  bit          p_v    = 0;
  logic [127:0] p_ts  = '0;

  task automatic apply(input logic [127:0] t);
    int c;
    c = classify(t);
    if (c == 0) begin
      m_type = 0; m_syms = '0; m_cnt = 0; m_err = 1;
    end else if (m_type == c && m_syms == t[119:80]) begin
      if (m_cnt < 15) m_cnt++;
    end else begin
      m_type = c; m_syms = t[119:80]; m_cnt = 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      m_err = 0;
      if (rst || ts_rcv_clr) begin
        m_type = 0; m_syms = '0; m_cnt = 0; p_v = 0;
      end else begin
        if (p_v) apply(p_ts);
        p_v  = rx_ts_valid;
        p_ts = rx_ts;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("m_type", 64'(typ),  64'(m_type));
      chk("m_link", 64'(link), 64'(m_syms[39:32]));
      chk("m_lane", 64'(lane), 64'(m_syms[31:24]));
      chk("m_rate", 64'(rate), 64'(m_syms[13:8]));
      chk("m_cnt",  64'(cnt),  64'(m_cnt));
      chk("m_err",  64'(err),  64'(m_err));
      chk("m_ts1",  64'(ts1_en), 64'(m_type == 1 && m_cnt >= 8));
      chk("m_ts2",  64'(ts2_en), 64'(m_type == 2 && m_cnt >= 8));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input logic [127:0] t, input bit clr);
    rx_ts_valid = v; rx_ts = t; ts_rcv_clr = clr;
    @(posedge clk); #1;
    rx_ts_valid = 0; ts_rcv_clr = 0;
  endtask

  task automatic send_n(input int n, input logic [127:0] t);
    for (int i = 0; i < n; i++) cyc(1, t, 0);
  endtask

  logic [127:0] ts1, ts2, ts1r6, bad0, mix;

  initial begin
    ts1   = mk(8'hBC, 8'h02, 8'h4A);
    ts2   = mk(8'hBC, 8'h02, 8'h45);
    ts1r6 = mk(8'hBC, 8'h06, 8'h4A);
    bad0  = mk(8'h00, 8'h02, 8'h4A);
    mix   = {8'hBC, 8'hF7, 8'hF7, 8'hFF, 8'h02, 8'h00, {5{8'h4A}}, {5{8'h45}}};
    rst = 1; rx_ts_valid = 0; rx_ts = '0; ts_rcv_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_type", 64'(typ), 64'd0);
    chk("rst_flags", 64'({ts1_en, ts2_en, err}), 64'd0);
    rst = 0;
    cyc(0, '0, 0);

    // polling run: 8 back-to-back TS1s
    send_n(8, ts1);
    chk("poll_cnt7", 64'(cnt), 64'd7);
    chk("poll_flag_early", 64'(ts1_en), 64'd0);
    cyc(0, '0, 0);
    chk("poll_cnt8", 64'(cnt), 64'd8);
    chk("poll_flag", 64'(ts1_en), 64'd1);
    chk("poll_link", 64'(link), 64'hF7);
    chk("poll_lane", 64'(lane), 64'hF7);
    chk("poll_rate", 64'(rate), 64'h02);
    chk("poll_type", 64'(typ), 64'd1);

    // switch to TS2
    cyc(1, ts2, 0);
    cyc(0, '0, 0);
    chk("sw_ts1_drop", 64'(ts1_en), 64'd0);
    chk("sw_cnt1", 64'(cnt), 64'd1);
    chk("sw_type", 64'(typ), 64'd2);
    send_n(7, ts2);
    cyc(0, '0, 0);
    chk("sw_ts2_flag", 64'(ts2_en), 64'd1);

    // key mismatch on rate
    cyc(0, '0, 1);
    send_n(5, ts1);
    cyc(1, ts1r6, 0);
    cyc(0, '0, 0);
    chk("km_cnt1", 64'(cnt), 64'd1);
    chk("km_rate", 64'(rate), 64'h06);
    send_n(7, ts1r6);
    cyc(0, '0, 0);
    chk("km_cnt8", 64'(cnt), 64'd8);

    // invalid sets mid-run, including back-to-back
    cyc(1, bad0, 0);
    cyc(0, '0, 0);
    chk("inv_err", 64'(err), 64'd1);
    chk("inv_cnt", 64'(cnt), 64'd0);
    chk("inv_type", 64'(typ), 64'd0);
    chk("inv_flags", 64'({ts1_en, ts2_en}), 64'd0);
    cyc(0, '0, 0);
    chk("inv_err_pulse", 64'(err), 64'd0);
    send_n(3, ts1);
    cyc(1, mix, 0);
    cyc(1, bad0, 0);
    chk("mix_err", 64'(err), 64'd1);
    cyc(0, '0, 0);
    chk("b2b_err", 64'(err), 64'd1);
    chk("b2b_cnt", 64'(cnt), 64'd0);

    // clear coincident with a valid TS1 at cnt 7
    send_n(7, ts1);
    cyc(0, '0, 0);
    chk("clr_pre_cnt", 64'(cnt), 64'd7);
    cyc(1, ts1, 1);
    chk("clr_cnt", 64'(cnt), 64'd0);
    cyc(0, '0, 0);
    chk("clr_cnt_after", 64'(cnt), 64'd0);
    chk("clr_no_err", 64'(err), 64'd0);

    // reset mid-run with a TS in flight
    send_n(4, ts1);
    rst = 1;
    cyc(1, ts1, 0);
    chk("rst_mid", 64'({typ, link, lane, rate, cnt, err, ts1_en, ts2_en}), 64'd0);
    rst = 0;
    cyc(0, '0, 0);
    chk("rst_mid_drop", 64'(cnt), 64'd0);

    // saturation with gaps
    for (int i = 0; i < 20; i++) begin
      cyc(1, ts1, 0);
      cyc(0, '0, 0);
    end
    cyc(0, '0, 0);
    chk("sat_cnt", 64'(cnt), 64'd15);
    chk("sat_flag", 64'(ts1_en), 64'd1);

    repeat (3) cyc(0, '0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
